// File: rtl/wdt_window_timer.sv
// Windowed watchdog: prescaled up-counter, early warning, fixed-width bite pulse.
// Define WDT_WINDOW_EN to reject kicks arriving while cnt < win_open.
module wdt_window_timer #(
  parameter int CNT_W     = 32,
  parameter int PRE_W     = 8,
  parameter int RST_PULSE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [PRE_W-1:0] prescale,
  input  logic [CNT_W-1:0] timeout,
  input  logic [CNT_W-1:0] warn_at,
  input  logic [CNT_W-1:0] win_open,
  input  logic             kick,
  output logic [CNT_W-1:0] cnt,
  output logic [1:0]       state,
  output logic             irq_warn,
  output logic             wdt_rst,
  output logic             bad_kick
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_WARN = 2'b10,
    ST_BITE = 2'b11
  } state_t;

  localparam int PW =
    (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam logic [PW-1:0] PULSE_LAST =
    PW'(RST_PULSE - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [PRE_W-1:0] r_pre;
  logic [PW-1:0]    r_pulse;
  logic             r_irq;
  logic             r_rst;
  logic             r_bad;

  logic w_tick;
  logic w_expire;
  logic w_warn;
  logic w_early;

  assign w_tick   = (r_pre == prescale);
  assign w_expire = w_tick && (r_cnt >= timeout);
  assign w_warn   = (r_cnt >= warn_at);

`ifdef WDT_WINDOW_EN
  assign w_early = (win_open != '0) &&
                   (r_cnt < win_open);
`else
  logic w_unused_win;
  assign w_unused_win = ^win_open;
  assign w_early      = 1'b0;
`endif

  // Watchdog FSM with count, prescaler, pulse timer and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pre   <= '0;
      r_pulse <= '0;
      r_irq   <= 1'b0;
      r_rst   <= 1'b0;
      r_bad   <= 1'b0;
    end else begin
      r_bad <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          r_pre <= '0;
          r_irq <= 1'b0;
          r_rst <= 1'b0;
          if (en) r_state <= ST_RUN;
        end
        ST_RUN, ST_WARN: begin
          if (!en) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pre   <= '0;
            r_irq   <= 1'b0;
          end else if (kick && w_early) begin
            r_state <= ST_BITE;
            r_cnt   <= '0;
            r_pre   <= '0;
            r_irq   <= 1'b0;
            r_rst   <= 1'b1;
            r_pulse <= '0;
            r_bad   <= 1'b1;
          end else if (kick) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_pre   <= '0;
            r_irq   <= 1'b0;
          end else if (w_expire) begin
            r_state <= ST_BITE;
            r_cnt   <= '0;
            r_pre   <= '0;
            r_irq   <= 1'b0;
            r_rst   <= 1'b1;
            r_pulse <= '0;
          end else begin
            if (w_tick) begin
              r_pre <= '0;
              r_cnt <= r_cnt + CNT_W'(1);
            end else begin
              r_pre <= r_pre + PRE_W'(1);
            end
            if (r_state == ST_WARN || w_warn) begin
              r_state <= ST_WARN;
              r_irq   <= 1'b1;
            end
          end
        end
        ST_BITE: begin
          r_cnt <= '0;
          r_pre <= '0;
          if (r_pulse == PULSE_LAST) begin
            r_rst   <= 1'b0;
            r_pulse <= '0;
            r_state <= en ? ST_RUN : ST_IDLE;
          end else begin
            r_pulse <= r_pulse + PW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cnt      = r_cnt;
  assign state    = r_state;
  assign irq_warn = r_irq;
  assign wdt_rst  = r_rst;
  assign bad_kick = r_bad;

endmodule

// File: tb/tb_wdt_window_timer.sv
// Scoreboard bench for wdt_window_timer: directed scenarios plus
// randomized traffic checked against a behavioural watchdog model.
module tb_wdt_window_timer;

  localparam int RST_PULSE = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        kick = 1'b0;
  logic [7:0]  prescale = '0;
  logic [31:0] timeout = '0;
  logic [31:0] warn_at = '0;
  logic [31:0] win_open = '0;
  logic [31:0] cnt;
  logic [1:0]  state;
  logic        irq_warn;
  logic        wdt_rst;
  logic        bad_kick;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [1:0]  st;
    logic [31:0] cnt;
    logic        irq;
    logic        rst;
    logic        bad;
  } obs_t;

  obs_t q[$];

  wdt_window_timer #(
    .CNT_W(32), .PRE_W(8), .RST_PULSE(RST_PULSE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .prescale(prescale), .timeout(timeout),
    .warn_at(warn_at), .win_open(win_open),
    .kick(kick), .cnt(cnt), .state(state),
    .irq_warn(irq_warn), .wdt_rst(wdt_rst),
    .bad_kick(bad_kick)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 run, 2 warn, 3 bite.
  int     m_st;
  longint m_cnt;
  int     m_pre;
  int     m_left;
  bit     m_bad;
  obs_t   m_next;

  int irq_at, rst_at, rst_len, rst_seen, nb;

  function automatic bit early();
`ifdef WDT_WINDOW_EN
    return (win_open != 0) && (m_cnt < longint'(win_open));
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_pre = 0;
    m_left = 0; m_bad = 0;
  endtask

  task automatic model_step();
    bit tick, warn, ill;
    m_bad = 0;
    ill = early();
    if (!rst_n) begin
      model_reset();
    end else begin
      case (m_st)
        0: begin
          m_cnt = 0; m_pre = 0;
          if (en) m_st = 1;
        end
        1, 2: begin
          if (!en) begin
            m_st = 0; m_cnt = 0; m_pre = 0;
          end else if (kick) begin
            m_cnt = 0; m_pre = 0;
            if (ill) begin
              m_st = 3; m_left = RST_PULSE; m_bad = 1;
            end else begin
              m_st = 1;
            end
          end else begin
            tick = (m_pre == int'(prescale));
            warn = (m_st == 2) || (m_cnt >= longint'(warn_at));
            if (tick && m_cnt >= longint'(timeout)) begin
              m_st = 3; m_left = RST_PULSE;
              m_cnt = 0; m_pre = 0;
            end else begin
              if (tick) begin
                m_cnt++; m_pre = 0;
              end else begin
                m_pre++;
              end
              m_st = warn ? 2 : 1;
            end
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) m_st = en ? 1 : 0;
        end
      endcase
    end
    m_next = {2'(m_st), 32'(m_cnt),
              m_st == 2, m_st == 3, m_bad};
  endtask

  task automatic tick_cycle();
    model_step();
    @(posedge clk);
    q.push_back(m_next);
    #1;
  endtask

  task automatic chk(input string name,
                     input longint got,
                     input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d",
               name, got, exp);
    end
  endtask

  task automatic do_reset();
    q.delete();
    rst_n = 1'b0;
    en = 1'b0;
    kick = 1'b0;
    model_reset();
    tick_cycle();
    tick_cycle();
    rst_n = 1'b1;
  endtask

  task automatic wait_cnt(input longint target,
                          input string name);
    bit ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if ((m_st == 1 || m_st == 2) && m_cnt == target)
        ok = 1;
      else
        tick_cycle();
    end
    chk(name, ok, 1);
  endtask

  task automatic wait_state(input int target,
                            input string name);
    bit ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (m_st == target) ok = 1;
      else tick_cycle();
    end
    chk(name, ok, 1);
  endtask

  // Monitor: every cycle the DUT presents a new registered output set.
  always @(negedge clk) begin
    obs_t e, g;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = {state, cnt, irq_warn, wdt_rst, bad_kick};
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t got st=%0d cnt=%0d irq=%b rst=%b bad=%b required st=%0d cnt=%0d irq=%b rst=%b bad=%b",
                 $time, g.st, g.cnt, g.irq, g.rst, g.bad,
                 e.st, e.cnt, e.irq, e.rst, e.bad);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    chk("reset_state", state, 0);
    chk("reset_cnt", cnt, 0);
    chk("reset_irq", irq_warn, 0);
    chk("reset_rst", wdt_rst, 0);
    chk("reset_bad", bad_kick, 0);
    do_reset();

    // Basic expiry: ticks every 4 cycles, warn at 3, bite after tick 6.
    prescale = 3; timeout = 5; warn_at = 3; win_open = 0;
    en = 1;
    tick_cycle();
    irq_at = -1; rst_at = -1; rst_len = 0;
    for (int k = 1; k <= 45; k++) begin
      tick_cycle();
      if (irq_warn && irq_at < 0) irq_at = k;
      if (wdt_rst) begin
        if (rst_at < 0) rst_at = k;
        rst_len++;
      end
      if (k == 40) begin
        chk("expiry_back_run", state, 1);
        chk("expiry_back_cnt", cnt, 0);
      end
    end
    chk("warn_cycle", irq_at, 13);
    chk("bite_cycle", rst_at, 24);
    chk("bite_len", rst_len, 16);

    // Kick service every 12 cycles.
    do_reset();
    prescale = 3; timeout = 5; warn_at = 3;
    en = 1; rst_seen = 0;
    for (int i = 0; i < 200; i++) begin
      kick = (i % 12 == 11);
      tick_cycle();
      if (wdt_rst) rst_seen++;
    end
    kick = 0;
    chk("kick_no_bite", rst_seen, 0);

    // Kick coinciding with the expiry tick.
    do_reset();
    prescale = 0; timeout = 2; warn_at = 10; en = 1;
    wait_cnt(2, "wait_cnt2_sim");
    kick = 1;
    tick_cycle();
    kick = 0;
    chk("sim_kick_state", state, 1);
    chk("sim_kick_cnt", cnt, 0);
    chk("sim_kick_rst", wdt_rst, 0);

    // Disable while warning.
    do_reset();
    prescale = 0; timeout = 20; warn_at = 2; en = 1;
    wait_state(2, "wait_warn");
    en = 0;
    tick_cycle();
    chk("dis_warn_state", state, 0);
    chk("dis_warn_cnt", cnt, 0);
    chk("dis_warn_irq", irq_warn, 0);

    // Disable during bite keeps the full pulse.
    timeout = 0; en = 1;
    wait_state(3, "wait_bite");
    en = 0; nb = wdt_rst ? 1 : 0;
    for (int i = 0; i < 24; i++) begin
      tick_cycle();
      if (wdt_rst) nb++;
    end
    chk("dis_bite_len", nb, 16);
    chk("dis_bite_idle", state, 0);

    // Window check.
    do_reset();
    prescale = 0; timeout = 20; warn_at = 20;
    win_open = 4; en = 1;
    wait_cnt(2, "wait_cnt2_win");
    kick = 1;
    tick_cycle();
    kick = 0;
`ifdef WDT_WINDOW_EN
    chk("early_bad", bad_kick, 1);
    chk("early_state", state, 3);
    chk("early_rst", wdt_rst, 1);
    tick_cycle();
    chk("early_bad_pulse", bad_kick, 0);
`else
    chk("nowin_bad", bad_kick, 0);
    chk("nowin_cnt", cnt, 0);
    chk("nowin_state", state, 1);
`endif
    wait_cnt(4, "wait_cnt4_win");
    kick = 1;
    tick_cycle();
    kick = 0;
    chk("open_bad", bad_kick, 0);
    chk("open_cnt", cnt, 0);
    chk("open_state", state, 1);
    win_open = 0;

    // Asynchronous reset in cycle 3 of a bite pulse.
    do_reset();
    prescale = 0; timeout = 0; warn_at = 5; en = 1;
    wait_state(3, "wait_bite2");
    tick_cycle();
    tick_cycle();
    #2;
    q.delete();
    rst_n = 0;
    #1;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_cnt", cnt, 0);
    chk("mid_rst_irq", irq_warn, 0);
    chk("mid_rst_rst", wdt_rst, 0);
    chk("mid_rst_bad", bad_kick, 0);
    model_reset();
    tick_cycle();
    rst_n = 1;

    // Randomized traffic against the model.
    for (int s = 0; s < 25; s++) begin
      en = 0; kick = 0;
      tick_cycle();
      tick_cycle();
      prescale = 8'($urandom_range(0, 3));
      timeout  = $urandom_range(0, 12);
      warn_at  = $urandom_range(0, 14);
      win_open = $urandom_range(0, 6);
      for (int i = 0; i < 60; i++) begin
        kick = ($urandom_range(0, 7) == 0);
        en = ($urandom_range(0, 49) != 0);
        if ($urandom_range(0, 29) == 0)
          timeout = $urandom_range(0, 12);
        tick_cycle();
      end
    end
    kick = 0; en = 0;
    tick_cycle();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
